// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Control FSM for a multicycle MIPS-style datapath. It drives
//               datapath selects and enables from the current state.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [2:0] alucontrol,
    output logic       imm_ext,
    output logic       instr_done,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        IMMWB   = 4'd10,
        JEX     = 4'd11,
        BNEEX   = 4'd12,
        ANDIEX  = 4'd13,
        ORIEX   = 4'd14
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SUB = 3'b110;
    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;
    localparam logic [2:0] c_ALU_SLT = 3'b111;

    // Kept as a plain vector so the unused code 15 is representable.
    logic [3:0] state_q;
    logic [3:0] state_d;

    always_comb begin : next_state
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                case (op)
                    c_OP_LW, c_OP_SW: state_d = MEMADR;
                    c_OP_RTYPE:       state_d = RTYPEEX;
                    c_OP_BEQ:         state_d = BEQEX;
                    c_OP_BNE:         state_d = BNEEX;
                    c_OP_ADDI:        state_d = ADDIEX;
                    c_OP_ANDI:        state_d = ANDIEX;
                    c_OP_ORI:         state_d = ORIEX;
                    c_OP_J:           state_d = JEX;
                    default:          state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (op == c_OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_d = MEMWB;
            RTYPEEX: state_d = RTYPEWB;
            ADDIEX,
            ANDIEX,
            ORIEX:   state_d = IMMWB;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin : state_reg
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : decode_outputs
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        pcen       = 1'b0;
        alucontrol = c_ALU_ADD;
        imm_ext    = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            FETCH: begin
                alusrcb = 2'b01;
                irwrite = 1'b1;
                pcen    = 1'b1;
            end
            DECODE: begin
                alusrcb = 2'b11;
                // Undefined opcodes retire here without touching any state.
                case (op)
                    c_OP_LW, c_OP_SW, c_OP_RTYPE, c_OP_BEQ, c_OP_BNE,
                    c_OP_ADDI, c_OP_ANDI, c_OP_ORI, c_OP_J: instr_done = 1'b0;
                    default:                                 instr_done = 1'b1;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                memtoreg   = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            MEMWR: begin
                iord       = 1'b1;
                memwrite   = 1'b1;
                instr_done = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                case (funct)
                    6'b100010: alucontrol = c_ALU_SUB;
                    6'b100100: alucontrol = c_ALU_AND;
                    6'b100101: alucontrol = c_ALU_OR;
                    6'b101010: alucontrol = c_ALU_SLT;
                    default:   alucontrol = c_ALU_ADD;
                endcase
            end
            RTYPEWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            BEQEX, BNEEX: begin
                alusrca    = 1'b1;
                alucontrol = c_ALU_SUB;
                pcsrc      = 2'b01;
                instr_done = 1'b1;
                pcen       = (state_q == BEQEX) ? zero : ~zero;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ANDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = c_ALU_AND;
                imm_ext    = 1'b1;
            end
            ORIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = c_ALU_OR;
                imm_ext    = 1'b1;
            end
            IMMWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            JEX: begin
                pcsrc      = 2'b10;
                pcen       = 1'b1;
                instr_done = 1'b1;
            end
            default: begin
                alucontrol = c_ALU_ADD;
            end
        endcase
    end

    assign state = state_q;

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have no parameters; all encodings below are fixed.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset: clk, reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset, sampled on the clk rising edge.
REQ-005 op  input  6  opcode field of the instruction register.
REQ-006 funct  input  6  funct field of the instruction register.
REQ-007 zero  input  1  ALU zero flag of the current cycle.
REQ-008 iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-009 memwrite  output  1  data memory write strobe.
REQ-010 irwrite  output  1  instruction register load enable.
REQ-011 regdst, memtoreg, regwrite  output  1 each  register-file destination select, write-data select, write enable.
REQ-012 alusrca  output  1 (0 = PC, 1 = A); alusrcb  output  2 (00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2).
REQ-013 pcsrc  output  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
REQ-014 pcen  output  1  PC load enable.
REQ-015 alucontrol  output  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-016 imm_ext  output  1  immediate extension: 1 = zero-extend, 0 = sign-extend.
REQ-017 instr_done  output  1  one-cycle pulse in the final state of each instruction.
REQ-018 state  output  4  current state encoding, for debug.

Function
REQ-019 The block SHALL be a state machine with a registered 4-bit state and these encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, IMMWB=10, JEX=11, BNEEX=12, ANDIEX=13, ORIEX=14.
REQ-020 All outputs except pcen SHALL be a combinational function of state only; pcen SHALL additionally depend on zero in the same cycle.
REQ-021 Any output not listed for a state SHALL be 0, except alucontrol, which SHALL default to 010.
REQ-022 FETCH SHALL drive: iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, irwrite=1, pcen=1; next state DECODE.
REQ-023 DECODE SHALL drive alusrca=0, alusrcb=11, alucontrol=010, and SHALL branch on op:
  - 100011 or 101011 -> MEMADR
  - 000000 -> RTYPEEX
  - 000100 -> BEQEX; 000101 -> BNEEX
  - 001000 -> ADDIEX; 001100 -> ANDIEX; 001101 -> ORIEX
  - 000010 -> JEX
  - any other op -> FETCH, with instr_done=1 and no writes.
REQ-024 MEMADR SHALL drive alusrca=1, alusrcb=10, alucontrol=010; next state MEMRD if op=100011, otherwise MEMWR.
REQ-025 MEMRD SHALL drive iord=1 and go to MEMWB; MEMWB SHALL drive memtoreg=1, regwrite=1, instr_done=1 and go to FETCH.
REQ-026 MEMWR SHALL drive iord=1, memwrite=1, instr_done=1 and go to FETCH.
REQ-027 RTYPEEX SHALL drive alusrca=1, alusrcb=00 and decode funct to alucontrol: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other->010; next state RTYPEWB.
REQ-028 RTYPEWB SHALL drive regdst=1, regwrite=1, instr_done=1 and go to FETCH.
REQ-029 BEQEX and BNEEX SHALL drive alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, instr_done=1 and go to FETCH; pcen SHALL be zero in BEQEX and ~zero in BNEEX.
REQ-030 ADDIEX, ANDIEX and ORIEX SHALL drive alusrca=1, alusrcb=10 with alucontrol 010 / 000 / 001 respectively.
REQ-031 ANDIEX and ORIEX SHALL also drive imm_ext=1; all three states SHALL go to IMMWB.
REQ-032 IMMWB SHALL drive regdst=0, memtoreg=0, regwrite=1, instr_done=1 and go to FETCH.
REQ-033 JEX SHALL drive pcsrc=10, pcen=1, instr_done=1 and go to FETCH.
REQ-034 Unused state code 15 SHALL drive all outputs 0, with alucontrol at its 010 default, and go to FETCH.
REQ-035 Instruction latency in cycles, FETCH through the instr_done state inclusive, SHALL be:
  - lw 5; sw 4; R-type 4; addi/andi/ori 4; beq/bne 3; j 3; undefined op 2.
REQ-036 Only one of memwrite, regwrite and irwrite SHALL ever be high in any cycle.

Reset
REQ-037 reset=1 at a rising edge SHALL force state to FETCH, overriding any transition, including mid-instruction; in-flight writes of the interrupted instruction SHALL NOT occur after that edge.
REQ-038 While reset is held, outputs SHALL show the FETCH values (pcen=1, irwrite=1); the datapath gates the PC register with its own reset.

Verification
REQ-039 lw (op=100011) after reset release -> states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; instr_done pulses once, in cycle 5.
REQ-040 beq with zero=1 in BEQEX -> pcen=1, pcsrc=01; repeat with zero=0 -> pcen=0; bne with zero=0 -> pcen=1.
REQ-041 R-type funct=101010 -> alucontrol=111 in RTYPEEX, then regdst=1, regwrite=1 in RTYPEWB; funct=111111 -> alucontrol=010.
REQ-042 ori (op=001101) -> ORIEX with imm_ext=1 and alucontrol=001, then IMMWB with regwrite=1; addi -> imm_ext=0 and alucontrol=010.
REQ-043 op=111111 -> DECODE then FETCH; memwrite and regwrite stay 0 throughout; instr_done=1 in DECODE.
REQ-044 Assert reset in MEMWR (sw) -> the next state is FETCH and memwrite=0 in the cycle after the edge; also force state 15 -> FETCH on the next edge.
